// File: rtl/tile_move_ctrl_pkg.sv
// Shared definitions for the 8-puzzle move sequencer and its neighbours.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Contents: ALU opcodes, board cell addresses, goal tile values, move direction
// encoding, sequencer state enum and small lookup helpers.
package tile_move_ctrl_pkg;

    localparam int TMC_DATA_W = 17;
    localparam int TMC_CNT_W  = 16;

    // ALU opcodes understood by the shared datapath ALU.
    // TO_* ops return the address of the cell adjacent to alu_in1.
    localparam logic [3:0] OP_COPY     = 4'h0;
    localparam logic [3:0] OP_COMP     = 4'h1;
    localparam logic [3:0] OP_TO_UP    = 4'h2;
    localparam logic [3:0] OP_TO_DOWN  = 4'h3;
    localparam logic [3:0] OP_TO_LEFT  = 4'h4;
    localparam logic [3:0] OP_TO_RIGHT = 4'h5;

    // Board register file: cells are row-major and contiguous.
    localparam logic [TMC_DATA_W-1:0] TEMP_0_ADDR = 17'd16;
    localparam logic [TMC_DATA_W-1:0] TEMP_1_ADDR = 17'd17;
    localparam logic [TMC_DATA_W-1:0] TEMP_2_ADDR = 17'd18;
    localparam logic [TMC_DATA_W-1:0] TEMP_3_ADDR = 17'd19;
    localparam logic [TMC_DATA_W-1:0] TEMP_4_ADDR = 17'd20;
    localparam logic [TMC_DATA_W-1:0] TEMP_5_ADDR = 17'd21;
    localparam logic [TMC_DATA_W-1:0] TEMP_6_ADDR = 17'd22;
    localparam logic [TMC_DATA_W-1:0] TEMP_7_ADDR = 17'd23;
    localparam logic [TMC_DATA_W-1:0] TEMP_8_ADDR = 17'd24;

    // Solved board: tiles 1..8 in order, blank (0) in the last cell.
    localparam logic [TMC_DATA_W-1:0] GOAL_0 = 17'd1;
    localparam logic [TMC_DATA_W-1:0] GOAL_1 = 17'd2;
    localparam logic [TMC_DATA_W-1:0] GOAL_2 = 17'd3;
    localparam logic [TMC_DATA_W-1:0] GOAL_3 = 17'd4;
    localparam logic [TMC_DATA_W-1:0] GOAL_4 = 17'd5;
    localparam logic [TMC_DATA_W-1:0] GOAL_5 = 17'd6;
    localparam logic [TMC_DATA_W-1:0] GOAL_6 = 17'd7;
    localparam logic [TMC_DATA_W-1:0] GOAL_7 = 17'd8;
    localparam logic [TMC_DATA_W-1:0] GOAL_8 = 17'd0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WR_BLANK,
        S_WR_NEIGH,
        S_CMP,
        S_DONE
    } state_t;

    function automatic logic [TMC_DATA_W-1:0] temp_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return TEMP_0_ADDR;
            4'd1:    return TEMP_1_ADDR;
            4'd2:    return TEMP_2_ADDR;
            4'd3:    return TEMP_3_ADDR;
            4'd4:    return TEMP_4_ADDR;
            4'd5:    return TEMP_5_ADDR;
            4'd6:    return TEMP_6_ADDR;
            4'd7:    return TEMP_7_ADDR;
            default: return TEMP_8_ADDR;
        endcase
    endfunction

    function automatic logic [TMC_DATA_W-1:0] goal_val(input logic [3:0] idx);
        case (idx)
            4'd0:    return GOAL_0;
            4'd1:    return GOAL_1;
            4'd2:    return GOAL_2;
            4'd3:    return GOAL_3;
            4'd4:    return GOAL_4;
            4'd5:    return GOAL_5;
            4'd6:    return GOAL_6;
            4'd7:    return GOAL_7;
            default: return GOAL_8;
        endcase
    endfunction

    function automatic logic [3:0] op_for_dir(input dir_t dir);
        case (dir)
            DIR_UP:   return OP_TO_UP;
            DIR_DOWN: return OP_TO_DOWN;
            DIR_LEFT: return OP_TO_LEFT;
            default:  return OP_TO_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/tile_move_ctrl_if.sv
// Bundle of command, ALU, board register file and status signals of the move sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready, ready high only while the sequencer is idle.
// Modports: master = sequencer side, slave = search logic / ALU / register file side.
// Optional: SOLVED_CHECK_EN adds the solved status bit.
interface tile_move_ctrl_if #(
    parameter int DATA_W = 17,
    parameter int CNT_W  = 16
);
    logic              load_blank;
    logic [3:0]        load_idx;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_dir;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_in0;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zf;
    logic [DATA_W-1:0] rf_addr;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              done;
    logic              done_illegal;
    logic [3:0]        blank_idx;
    logic [CNT_W-1:0]  move_cnt;
`ifdef SOLVED_CHECK_EN
    logic              solved;
`endif

    modport master (
        input  load_blank, load_idx, cmd_valid, cmd_dir, alu_out, alu_zf, rf_rdata,
        output cmd_ready, alu_op, alu_in0, alu_in1, rf_addr, rf_we, rf_wdata,
        output done, done_illegal, blank_idx, move_cnt
`ifdef SOLVED_CHECK_EN
        , output solved
`endif
    );

    modport slave (
        output load_blank, load_idx, cmd_valid, cmd_dir, alu_out, alu_zf, rf_rdata,
        input  cmd_ready, alu_op, alu_in0, alu_in1, rf_addr, rf_we, rf_wdata,
        input  done, done_illegal, blank_idx, move_cnt
`ifdef SOLVED_CHECK_EN
        , input solved
`endif
    );
endinterface

// File: rtl/tile_move_ctrl_move_legal_chk.sv
// Edge legality of a blank move on the 3x3 board and the resulting blank index.
// Latency: combinational.
// Backpressure: none.
// Ports: idx (blank index 0..8), dir, legal, new_idx (equals idx when not legal).
module move_legal_chk
    import tile_move_ctrl_pkg::*;
(
    input  logic [3:0] idx,
    input  dir_t       dir,
    output logic       legal,
    output logic [3:0] new_idx
);
    logic [1:0] col;

    always_comb begin
        col = 2'd0;
        case (idx)
            4'd1, 4'd4, 4'd7: col = 2'd1;
            4'd2, 4'd5, 4'd8: col = 2'd2;
            default:          col = 2'd0;
        endcase

        legal   = 1'b0;
        new_idx = idx;
        if (idx <= 4'd8) begin
            case (dir)
                DIR_UP:    begin legal = (idx >= 4'd3); new_idx = idx - 4'd3; end
                DIR_DOWN:  begin legal = (idx <= 4'd5); new_idx = idx + 4'd3; end
                DIR_LEFT:  begin legal = (col != 2'd0); new_idx = idx - 4'd1; end
                default:   begin legal = (col != 2'd2); new_idx = idx + 4'd1; end
            endcase
        end
        if (!legal) begin
            new_idx = idx;
        end
    end
endmodule

// File: rtl/tile_move_ctrl.sv
// Move sequencer: slides one tile into the blank via the shared ALU and board register file.
// Latency: accept edge to done pulse 5 cycles legal (14 with SOLVED_CHECK_EN), 2 cycles illegal.
// Backpressure: cmd_ready only in IDLE; cmd_valid outside IDLE is dropped, not queued.
// Ports: clk, rst_n (async active-low), bus (tile_move_ctrl_if.master: command, ALU,
// register file, done/done_illegal, blank_idx, move_cnt). Optional macro SOLVED_CHECK_EN
// adds a goal comparison pass after each legal move and the solved status bit.
module tile_move_ctrl
    import tile_move_ctrl_pkg::*;
#(
    parameter int DATA_W = TMC_DATA_W,
    parameter int CNT_W  = TMC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    tile_move_ctrl_if.master bus
);
    state_t            state_q, state_d;
    dir_t              dir_q;
    logic              illegal_q;
    logic [DATA_W-1:0] nb_addr_q;
    logic [DATA_W-1:0] tile_q;
    logic [3:0]        blank_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              legal_w;
    logic [3:0]        new_idx_w;

    logic [3:0]        alu_op_c;
    logic [DATA_W-1:0] alu_in0_c, alu_in1_c, rf_addr_c, rf_wdata_c;
    logic              rf_we_c, done_c, done_ill_c, cmd_ready_c;

    move_legal_chk u_legal (
        .idx     (blank_q),
        .dir     (dir_q),
        .legal   (legal_w),
        .new_idx (new_idx_w)
    );

`ifdef SOLVED_CHECK_EN
    logic [3:0] cmp_idx_q;
    logic       all_eq_q;
    logic       solved_q;
`else
    logic       unused_zf;
    assign unused_zf = bus.alu_zf;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.load_blank && bus.cmd_valid) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK:    state_d = legal_w ? S_READ : S_DONE;
            S_READ:     state_d = S_WR_BLANK;
            S_WR_BLANK: state_d = S_WR_NEIGH;
`ifdef SOLVED_CHECK_EN
            S_WR_NEIGH: state_d = S_CMP;
            S_CMP:      state_d = (cmp_idx_q == 4'd8) ? S_DONE : S_CMP;
`else
            S_WR_NEIGH: state_d = S_DONE;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs. The legality check and the neighbour address lookup share the CHECK
    // cycle: the TO_* result is captured unconditionally and only used when legal.
    always_comb begin
        alu_op_c    = OP_COPY;
        alu_in0_c   = '0;
        alu_in1_c   = '0;
        rf_addr_c   = '0;
        rf_we_c     = 1'b0;
        rf_wdata_c  = '0;
        done_c      = 1'b0;
        done_ill_c  = 1'b0;
        cmd_ready_c = 1'b0;
        case (state_q)
            S_IDLE: cmd_ready_c = 1'b1;
            S_CHECK: begin
                alu_op_c  = op_for_dir(dir_q);
                alu_in1_c = DATA_W'(temp_addr(blank_q));
            end
            S_READ: rf_addr_c = nb_addr_q;
            S_WR_BLANK: begin
                alu_op_c   = OP_COPY;
                alu_in1_c  = tile_q;
                rf_addr_c  = DATA_W'(temp_addr(blank_q));
                rf_wdata_c = bus.alu_out;
                rf_we_c    = 1'b1;
            end
            S_WR_NEIGH: begin
                rf_addr_c = nb_addr_q;
                rf_we_c   = 1'b1;
            end
`ifdef SOLVED_CHECK_EN
            S_CMP: begin
                alu_op_c  = OP_COMP;
                rf_addr_c = DATA_W'(temp_addr(cmp_idx_q));
                alu_in0_c = bus.rf_rdata;
                alu_in1_c = DATA_W'(goal_val(cmp_idx_q));
            end
`endif
            S_DONE: begin
                done_c     = 1'b1;
                done_ill_c = illegal_q;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q   <= 4'd8;
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            illegal_q <= 1'b0;
            nb_addr_q <= '0;
            tile_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load_blank) begin
                        if (bus.load_idx <= 4'd8) begin
                            blank_q <= bus.load_idx;
                        end
                    end else if (bus.cmd_valid) begin
                        dir_q <= dir_t'(bus.cmd_dir);
                    end
                end
                S_CHECK: begin
                    illegal_q <= !legal_w;
                    nb_addr_q <= bus.alu_out;
                end
                S_READ: tile_q <= bus.rf_rdata;
                S_WR_NEIGH: begin
                    blank_q <= new_idx_w;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SOLVED_CHECK_EN
    // Goal comparison: one cell per CMP cycle, verdict lands on the edge into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_idx_q <= 4'd0;
            all_eq_q  <= 1'b1;
            solved_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (!legal_w) begin
                        solved_q <= 1'b0;
                    end
                end
                S_WR_NEIGH: begin
                    cmp_idx_q <= 4'd0;
                    all_eq_q  <= 1'b1;
                end
                S_CMP: begin
                    cmp_idx_q <= cmp_idx_q + 4'd1;
                    all_eq_q  <= all_eq_q & bus.alu_zf;
                    if (cmp_idx_q == 4'd8) begin
                        solved_q <= all_eq_q & bus.alu_zf;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.solved = solved_q;
`endif

    assign bus.cmd_ready    = cmd_ready_c;
    assign bus.alu_op       = alu_op_c;
    assign bus.alu_in0      = alu_in0_c;
    assign bus.alu_in1      = alu_in1_c;
    assign bus.rf_addr      = rf_addr_c;
    assign bus.rf_we        = rf_we_c;
    assign bus.rf_wdata     = rf_wdata_c;
    assign bus.done         = done_c;
    assign bus.done_illegal = done_ill_c;
    assign bus.blank_idx    = blank_q;
    assign bus.move_cnt     = cnt_q;
endmodule
